// File: rtl/mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_arb_pkg
//   Shared types and constants for the multiplier-sharing arbiter:
//   - mul_arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   - OPW / PRODW     : operand and product widths of the shared multiplier
//   - TIMEOUT_CYCLES_DEF : default WAIT watchdog limit (used only when the
//                          MULARB_TIMEOUT_EN build option is defined)
// -----------------------------------------------------------------------------
package mul_arb_pkg;

  localparam int OPW                = 8;
  localparam int PRODW              = 16;
  localparam int TIMEOUT_CYCLES_DEF = 63;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mul_arb_state_e;

endpackage : mul_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches req starting at ptr+1 and
//   wrapping modulo N; the first set bit wins. Written generically so other
//   ALU port arbiters can reuse it.
//
// Ports:
//   req   in  N     request vector
//   ptr   in  ID_W  index of the most recent winner
//   grant out N     one-hot winner, all zero when req is zero
//   idx   out ID_W  encoded winner index, zero when req is zero
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  int   cand;
  logic found;

  // NOTE: every variable written here gets a value before any condition is
  // evaluated; otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Offsets 1..N visit ptr+1 first and ptr itself last.
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

endmodule : rr_pick

// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//   Shares one start/done 8x8 signed multiplier between NUM_REQ requesters.
//   One transaction is outstanding at a time: IDLE picks a requester round-
//   robin, ISSUE pulses mul_start, WAIT holds operands until mul_done, RESP
//   presents the product to the winner until it accepts.
//
//   Build option: define MULARB_TIMEOUT_EN to add a WAIT watchdog. After
//   TIMEOUT_CYCLES WAIT cycles without mul_done the arbiter answers with
//   product 0 and rsp_error = 1. Without it WAIT blocks until mul_done and
//   rsp_error is tied low.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester operand handshake (ready one-hot or 0)
//   req_a/req_b         packed operands, slice i = [8i+7:8i]
//   rsp_valid/rsp_ready per-requester result handshake (valid one-hot or 0)
//   rsp_product         shared result bus, qualified by rsp_valid
//   rsp_error           timeout flag, qualified by rsp_valid
//   busy                high whenever the FSM is not in IDLE
//   mul_start           one-cycle start pulse to the multiplier
//   mul_a/mul_b         operands, stable from ISSUE through WAIT
//   mul_done            multiplier completion
//   mul_product         multiplier result, valid with mul_done
// -----------------------------------------------------------------------------
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
`ifdef MULARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [PRODW-1:0]       rsp_product,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   mul_start,
  output logic [OPW-1:0]         mul_a,
  output logic [OPW-1:0]         mul_b,
  input  logic                   mul_done,
  input  logic [PRODW-1:0]       mul_product
);

  mul_arb_state_e     state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [OPW-1:0]     mul_a_q, mul_a_d;
  logic [OPW-1:0]     mul_b_q, mul_b_d;
  logic [PRODW-1:0]   prod_q, prod_d;
  logic               mul_start_q, mul_start_d;

`ifdef MULARB_TIMEOUT_EN
  // At least 6 bits, wide enough to hold TIMEOUT_CYCLES-1.
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) < 6) ? 6 : $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
`endif

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic [OPW-1:0]     a_slot [NUM_REQ];
  logic [OPW-1:0]     b_slot [NUM_REQ];

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Unpack the operand buses so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_slot[i] = req_a[i*OPW +: OPW];
      b_slot[i] = req_b[i*OPW +: OPW];
    end
  end

  // Ready is only offered while idle; the picker already qualifies with valid,
  // so any ready bit means a handshake at this edge.
  assign req_ready = (state_q == IDLE) ? pick_grant : '0;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[id_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    prod_d      = prod_q;
    mul_start_d = 1'b0;
`ifdef MULARB_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (|req_ready) begin
          mul_a_d     = a_slot[pick_idx];
          mul_b_d     = b_slot[pick_idx];
          id_d        = pick_idx;
          ptr_d       = pick_idx;
          mul_start_d = 1'b1;  // high during the ISSUE cycle only
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
`ifdef MULARB_TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        if (mul_done) begin
          prod_d  = mul_product;
`ifdef MULARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
`ifdef MULARB_TIMEOUT_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th WAIT cycle without completion.
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end

      RESP: begin
        // Only the granted requester's ready bit can complete the response.
        if (rsp_ready[id_q]) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      id_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      prod_q      <= '0;
      mul_start_q <= 1'b0;
`ifdef MULARB_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      prod_q      <= prod_d;
      mul_start_q <= mul_start_d;
`ifdef MULARB_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_product = prod_q;
`ifdef MULARB_TIMEOUT_EN
  assign rsp_error   = err_q;
`else
  assign rsp_error   = 1'b0;
`endif

endmodule : mul_share_arbiter

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
//   Directed bench for mul_share_arbiter with NUM_REQ = 4. A behavioural
//   multiplier stub answers mul_start after a programmable number of WAIT
//   cycles (0 = done in the first WAIT cycle) and can be disabled to model a
//   hung multiplier. Inputs change 1 ns after the rising edge; outputs are
//   observed on the falling edge. Define MULARB_TIMEOUT_EN for the watchdog
//   scenario.
// -----------------------------------------------------------------------------
module tb_mul_share_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [15:0]   rsp_product, mul_product;
  logic          rsp_error, busy, mul_start, mul_done;
  logic [7:0]    mul_a, mul_b;

  // Multiplier stub controls and state.
  logic          stub_en;
  int            stub_lat;
  int            stub_cnt;
  logic          stub_done;
  logic [15:0]   stub_prod;
  logic          extra_done;

  int            n_vec  = 0;
  int            n_miss = 0;
  int            adj_viol = 0;
  logic          prev_start = 1'b0;
  logic          rec_en = 1'b0;
  int            grant_log[$];

  always #5 clk = ~clk;

  mul_share_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_error   (rsp_error),
    .busy        (busy),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  // Multiplier model: product of the sign-extended operands seen with start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_prod <= '0;
    end else begin
      stub_done <= 1'b0;
      if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) stub_done <= 1'b1;
      end
      if (mul_start && stub_en) begin
        stub_prod <= $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});
        if (stub_lat == 0) stub_done <= 1'b1;
        else               stub_cnt  <= stub_lat;
      end
    end
  end

  assign mul_done    = stub_done | extra_done;
  assign mul_product = stub_prod;

  // Passive monitors: adjacent start pulses and grant order.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (mul_start && prev_start) adj_viol++;
      prev_start = mul_start;
      if (rec_en && (req_valid & req_ready) != '0)
        for (int i = 0; i < N; i++) if (req_valid[i] & req_ready[i]) grant_log.push_back(i);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      step();
      @(negedge clk);
      n++;
    end
    check({tag, "_arrive"}, 32'(n < 200), 1);
  endtask

  // Wait for the response of requester id, check it, accept it. next_valid is
  // applied to req_valid in the accepting cycle.
  task automatic serve(input string tag, input int id, input logic [15:0] prod,
                       input logic err, input logic [N-1:0] next_valid);
    wait_valid(tag);
    check({tag, "_rsp_valid"}, rsp_valid, 32'(1) << id);
    check({tag, "_product"},   rsp_product, prod);
    check({tag, "_error"},     rsp_error, err);
    step();
    rsp_ready = N'(1) << id;
    req_valid = next_valid;
    @(negedge clk);
    step();
    rsp_ready = '0;
    @(negedge clk);
    check({tag, "_rsp_clear"}, rsp_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {req_ready, rsp_valid, mul_start, busy, rsp_error}, 0);
    check({tag, "_data"}, {rsp_product, mul_a, mul_b}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    req_valid  = '0;
    rsp_ready  = '0;
    req_a      = '0;
    req_b      = '0;
    stub_en    = 1'b1;
    stub_lat   = 3;
    extra_done = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;

    // Single request: 13 * 28 = 364.
    step();
    set_op(0, 8'd13, 8'd28);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_issue", {mul_start, busy, req_ready, mul_a, mul_b}, {1'b1, 1'b1, 4'b0000, 8'd13, 8'd28});
    step();
    @(negedge clk);
    check("t1_start_low", mul_start, 0);
    serve("t1", 0, 16'h016C, 1'b0, '0);
    check("t1_idle", busy, 0);

    // Two simultaneous requests from reset: req0 first, then req1.
    step();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    set_op(0, 8'hFB, 8'h07);
    set_op(1, 8'h06, 8'hFD);
    req_valid = 4'b0011;
    @(negedge clk);
    check("t2_first_grant", req_ready, 4'b0001);
    serve("t2_r0", 0, 16'hFFDD, 1'b0, 4'b0010);
    serve("t2_r1", 1, 16'hFFEE, 1'b0, 4'b0000);

    // Fairness: all four valid for eight transactions.
    step();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'd10);
    grant_log.delete();
    rec_en    = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++)
      serve($sformatf("t3_%0d", k), k % N, 16'((k % N + 1) * 10), 1'b0,
            (k == 7) ? 4'b0000 : 4'b1111);
    rec_en = 1'b0;
    check("t3_grant_count", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size() && k < 8; k++)
      check($sformatf("t3_grant_%0d", k), grant_log[k], k % N);

    // Backpressure on requester 2: (-7) * (-9) = 63.
    step();
    set_op(2, 8'hF9, 8'hF7);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t4_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    wait_valid("t4");
    for (int c = 0; c < 10; c++) begin
      step();
      rsp_ready = 4'b1011;  // other indices must be ignored
      req_valid = 4'b1011;  // nobody may be accepted while a response is pending
      @(negedge clk);
      check($sformatf("t4_hold_%0d", c), {rsp_valid, req_ready, rsp_product},
            {4'b0100, 4'b0000, 16'h003F});
    end
    step();
    rsp_ready = 4'b0100;
    req_valid = '0;
    @(negedge clk);
    step();
    rsp_ready = '0;
    @(negedge clk);
    check("t4_release", {rsp_valid, busy}, 0);

    // Fast path: done in the first WAIT cycle, 0 * 77 = 0.
    stub_lat = 0;
    step();
    set_op(3, 8'd0, 8'd77);
    req_valid = 4'b1000;
    @(negedge clk);
    check("t5_ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t5_issue", mul_start, 1);
    step();
    @(negedge clk);
    check("t5_wait1", {mul_done, rsp_valid}, {1'b1, 4'b0000});
    step();
    @(negedge clk);
    check("t5_rsp", {rsp_valid, rsp_product}, {4'b1000, 16'h0000});
    step();
    rsp_ready = 4'b1000;
    @(negedge clk);
    step();
    rsp_ready = '0;
    stub_lat  = 3;

    // Stray mul_done while idle is ignored.
    extra_done = 1'b1;
    @(negedge clk);
    step();
    extra_done = 1'b0;
    @(negedge clk);
    check("t6_stray_done", {rsp_valid, busy}, 0);

`ifdef MULARB_TIMEOUT_EN
    // Watchdog: no done for 63 WAIT cycles gives an error response.
    stub_en = 1'b0;
    step();
    set_op(1, 8'd3, 8'd3);
    req_valid = 4'b0010;
    @(negedge clk);
    step();
    req_valid = '0;
    @(negedge clk);
    n = 0;
    step();
    @(negedge clk);
    while (rsp_valid == '0 && n < 200) begin
      n++;
      step();
      @(negedge clk);
    end
    check("t7_wait_cycles", n, 63);
    serve("t7", 1, 16'h0000, 1'b1, '0);
`endif

    // Reset in the middle of WAIT with a hung multiplier.
    stub_en = 1'b0;
    step();
    set_op(1, 8'd3, 8'd3);
    req_valid = 4'b0010;
    @(negedge clk);
    step();
    req_valid = '0;
    n = 0;
    repeat (10) begin
      step();
      @(negedge clk);
      if (rsp_valid != '0) n++;
    end
    check("t8_still_waiting", {busy, 28'(n)}, {1'b1, 28'd0});
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t8_reset");
    step();
    rst_n   = 1'b1;
    stub_en = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 8'd2, 8'(i + 5));
    req_valid = 4'b1111;
    @(negedge clk);
    check("t8_next_grant", req_ready, 4'b0001);
    serve("t8", 0, 16'd10, 1'b0, '0);

    check("no_adjacent_start", adj_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mul_share_arbiter

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one radix-4 Booth multiplier unit (8x8 signed, 16-bit product, start/done interface) between NUM_REQ independent requesters.
- Performs round-robin selection of one requester and issues a single-cycle start pulse to the multiplier.
- Waits for done, then returns the product to the granted requester over a valid/ready response channel.
- Sits between the ALU front-end ports and the shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index.
- TIMEOUT_CYCLES, 63, watchdog limit in WAIT. Used only with MULARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*8  multiplicands; slice i = [8i+7:8i].
- req_b  in  NUM_REQ*8  multipliers, same slicing.
- rsp_valid  out  NUM_REQ  per-requester result valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_product  out  16  shared result bus; meaningful only where rsp_valid is set.
- rsp_error  out  1  result invalid (timeout); qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  8  multiplicand to the multiplier, held stable from ISSUE through WAIT.
- mul_b  out  8  multiplier operand, held the same way.
- mul_done  in  1  multiplier completion.
- mul_product  in  16  multiplier result, valid on the mul_done cycle.

Behaviour:
Reset:
- On rst_n low, asynchronously:
  - state = IDLE.
  - req_ready, rsp_valid, mul_start, busy, rsp_error all 0.
  - rsp_product, mul_a, mul_b = 0.
  - Grant pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction drops the transaction silently. The multiplier is reset by the same system reset.

States: IDLE, ISSUE, WAIT, RESP.

IDLE:
- req_ready is combinational: a one-hot bit for the first valid requester found searching from pointer+1, wrapping modulo NUM_REQ.
- On req_valid[g] & req_ready[g]:
  - Latch req_a/req_b slice g into mul_a/mul_b.
  - Latch g as the current ID.
  - Set pointer = g.
  - Go to ISSUE.
- Requesters must hold valid and operands stable until ready.

ISSUE:
- mul_start = 1 for exactly this one cycle, registered.
- Go to WAIT.
- mul_start is never high for two consecutive cycles.

WAIT:
- mul_start = 0.
- On mul_done, capture mul_product into rsp_product, set rsp_error = 0, go to RESP.
- mul_done can arrive as early as the first WAIT cycle (zero/one operand fast path). It must be captured there.

RESP:
- rsp_valid[ID] = 1. rsp_product and rsp_error are held stable.
- On rsp_ready[ID]: clear rsp_valid and go to IDLE.
- rsp_ready on any other index is ignored.
- Unlimited backpressure is allowed.

Latency and throughput:
- Accept cycle N gives mul_start at N+1.
- mul_done at cycle D gives rsp_valid at D+1.
- Back-to-back issues are separated by at least 2 cycles (RESP→IDLE→ISSUE). This guarantees the multiplier has cleared done before the next start.

Other rules:
- mul_done seen in IDLE, ISSUE or RESP is ignored.
- No new request is accepted before RESP completes (single outstanding).
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,…,NUM_REQ-1,0.
- Products are passed through unmodified as 16-bit signed. The arbiter performs no arithmetic.

Optional Feature:
- MULARB_TIMEOUT_EN defined:
  - A 6+ bit watchdog counts cycles in WAIT.
  - When it reaches TIMEOUT_CYCLES with no mul_done: go to RESP with rsp_product = 0 and rsp_error = 1.
  - A late mul_done arriving after the timeout is ignored under the same rule as above.
- Undefined:
  - No counter. WAIT blocks indefinitely.
  - rsp_error is tied to 0.

Decomposition:
- Package mul_arb_pkg:
  - State enum (IDLE, ISSUE, WAIT, RESP).
  - OPW = 8, PRODW = 16.
  - Default TIMEOUT_CYCLES constant.
- Sub-module rr_pick: combinational round-robin one-hot selector.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Reusable by future ALU port arbiters.

Test Plan:
- Single request, req0 a=13, b=28 -> mul_start one cycle after accept; rsp_valid[0] with product 364 (0x016C), rsp_error=0.
- req0 (-5,7) and req1 (6,-3) asserted together from reset -> req0 served first (-35 = 0xFFDD), then req1 (-18 = 0xFFEE).
- All 4 requesters held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3; mul_start never high on adjacent cycles.
- Backpressure: rsp_ready[2] held low 10 cycles -> rsp_valid[2] and product stable; req_ready all 0 throughout.
- Fast path: a=0, b=77, with mul_done in the first WAIT cycle -> product 0 returned; rsp_valid exactly one cycle after mul_done.
- With MULARB_TIMEOUT_EN, mul_done stubbed low -> rsp_error=1 and product 0 after 63 WAIT cycles. Separately, rst_n pulsed low mid-WAIT -> all outputs 0 and the next grant goes to requester 0.
